wb_debug_split: RTL and testbench
=================================

# wb_debug_split

Wishbone classic slave-side splitter for the user project area. It carves a parametrised window of debug registers out of the top of the user address space and routes every other access to the user project port. It also adds a bus-timeout watchdog that terminates hung user accesses with an error word and records them in a sticky status register. It sits directly behind the wrapper's Wishbone slave pins, in front of the user design.

## Interface
Parameters:
- `DBG_REGS`, default 2: number of 32-bit debug words; power of two, at least 2. Word `DBG_REGS-1` is status; the rest are R/W scratch.
- `WIN_TOP`, default 32'h300F_FFFF: last byte address of the user window. The debug window is the top `DBG_REGS*4` bytes below and including it.
- `TIMEOUT_CYC`, default 255: user-access timeout in cycles, at least 2.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_ni` in 1: reset, asynchronous active-low. Assertion clears all state immediately; deassertion is synchronous to `wb_clk_i`.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone master strobes.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i`, `wbs_dat_i` in 32 each: address and write data.
- `wbs_ack_o` out 1: ack to the master.
- `wbs_dat_o` out 32: read data to the master.
- `user_cyc_o`, `user_stb_o` out 1 each: gated strobes to the user design. Address, data, sel and we are wired straight through outside this block.
- `user_ack_i` in 1: ack from the user design.
- `user_dat_i` in 32: read data from the user design.
- `dbg_regs_o` out 32*(DBG_REGS-1): flattened scratch registers, word 0 in the LSBs.

## Operation
- Decode: `is_dbg = (wbs_adr_i[31:2] >> log2(DBG_REGS)) == (WIN_TOP[31:2] >> log2(DBG_REGS))`. Index = `wbs_adr_i[log2(DBG_REGS)+1:2]`.
- States: IDLE, DBG_ACK, USER, TO_ERR. Request = `wbs_cyc_i & wbs_stb_i`.
- IDLE, request with `is_dbg`: perform the write in this cycle, with sel-granular byte writes; go to DBG_ACK. Reads of word `DBG_REGS-1` return status.
- IDLE or USER, request with `!is_dbg`:
  - `user_cyc_o`/`user_stb_o` follow the master strobes.
  - `wbs_ack_o = user_ack_i` and `wbs_dat_o = user_dat_i`, combinationally.
  - On `user_ack_i` go to IDLE; otherwise go to USER and increment the timeout counter.
- DBG_ACK: `wbs_ack_o=1` for one cycle, with read data from a register captured at request time; then go to IDLE.
- USER timeout: if the counter equals `TIMEOUT_CYC-1` and `user_ack_i` is 0, go to TO_ERR. The user strobes drop to 0 in TO_ERR.
- TO_ERR: `wbs_ack_o=1` and `wbs_dat_o=32'hDEAD_BEEF` for one cycle. Set sticky flag `to_flag`, increment `to_count` (saturating at 16'hFFFF), then go to IDLE.
- Master abort: if `wbs_cyc_i` drops in USER, go to IDLE, clear the counter and issue no ack.
- The counter clears whenever the state machine enters IDLE.
- Status word layout: [31:16] `to_count`, [0] `to_flag`, other bits read 0. A write with `sel[0]` and bit0=1 clears both fields. That clear takes precedence over a simultaneous TO_ERR increment.
- Writes to any debug index other than scratch or status are impossible by construction. Upper address bits are always don't-care within the window.

## Timing
- Reset values:
  - `wbs_ack_o=0`, `wbs_dat_o=0`, user strobes 0.
  - `dbg_regs_o=0`, `to_count=0`, `to_flag=0`.
  - State IDLE, counter 0.
- Debug access: request sampled in cycle N, ack in cycle N+1. Exactly one ack per request, with no back-to-back retrigger because DBG_ACK ignores strobes.
- User access: zero added latency.
- Timeout: with the request first asserted in cycle 0 and no user ack, the error ack lands in cycle `TIMEOUT_CYC`.
- A `user_ack_i` in the same cycle the counter reaches `TIMEOUT_CYC-1` wins: normal ack, no error.
- A late `user_ack_i` in TO_ERR or IDLE with no pending request is ignored.
- Reset asserted mid-transaction drops ack and strobes in the same cycle, asynchronously.
- `wbs_dat_o` is 0 whenever `wbs_ack_o` is 0.

## Configuration
- `WB_TIMEOUT_EN` defined: the watchdog, TO_ERR state and status fields exist as described.
- `WB_TIMEOUT_EN` undefined:
  - USER waits indefinitely for `user_ack_i` or master abort.
  - The status word reads 0 and ignores writes.
  - Scratch registers and decode are unchanged.

## Test plan
- Reset check: after reset, `wbs_ack_o=0` and the status word reads 0.
- Debug write/read (`DBG_REGS=2`): write 32'hA5A5_1234 with sel 4'b0011 to 0x300F_FFF8 over a word holding 0, then read it back. Required: ack one cycle after each request, read data 32'h0000_1234, `dbg_regs_o=32'h0000_1234`.
- User passthrough: read 0x3000_0010 with the user acking in cycle 3 with 32'hCAFE_0001. Required: `wbs_ack_o` in cycle 3 with that data, and no write to any debug register.
- Timeout (`TIMEOUT_CYC=8`): user never acks. Required: ack in cycle 8 with 32'hDEAD_BEEF, user strobes low in cycle 8, status reads 32'h0001_0001.
- Ack-versus-timeout race and abort:
  - User acks in cycle 7 with `TIMEOUT_CYC=8`: normal ack, status unchanged.
  - `wbs_cyc_i` dropped in cycle 4: no ack, and the next access behaves normally.
- Status clear and reset mid-access:
  - Write 1 to status bit0: status reads 0.
  - Pull `wb_rst_ni` low during a pending user access: ack and strobes drop immediately and the scratch registers read 0.

Source files
------------

// File: rtl/wb_debug_split.sv
// wb_debug_split: Wishbone classic splitter carving debug registers out of the top of the user window.
// Build option: define WB_TIMEOUT_EN to add the user-access watchdog, TO_ERR state and status fields.
module wb_debug_split #(
    parameter int unsigned DBG_REGS    = 2,
    parameter logic [31:0] WIN_TOP     = 32'h300F_FFFF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    output logic                        user_cyc_o,
    output logic                        user_stb_o,
    input  logic                        user_ack_i,
    input  logic [31:0]                 user_dat_i,
    output logic [32*(DBG_REGS-1)-1:0]  dbg_regs_o
);
    localparam int unsigned      IDX_W    = $clog2(DBG_REGS);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [29:0]      WIN_WORD = WIN_TOP[31:2] >> IDX_W;

    typedef enum logic [1:0] {IDLE, DBG_ACK, USER, TO_ERR} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [32*(DBG_REGS-1)-1:0]  scratch_q;
    logic [31:0]                 rd_dat_p1;
    logic [31:0]                 status_word;
    logic [31:0]                 dbg_rd;
    logic [IDX_W-1:0]            idx;
    logic                        req, is_dbg, dbg_hit, dbg_wr, to_hit, route;
    logic                        unused_adr;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign is_dbg     = (wbs_adr_i[31:2] >> IDX_W) == WIN_WORD;
    assign idx        = wbs_adr_i[IDX_W+1:2];
    assign dbg_hit    = (state_q == IDLE) & req & is_dbg;
    assign dbg_wr     = dbg_hit & wbs_we_i;
    assign unused_adr = ^wbs_adr_i[1:0];
    assign dbg_regs_o = scratch_q;

`ifdef WB_TIMEOUT_EN
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(DBG_REGS - 1);

    logic [15:0] to_count_q;
    logic        to_flag_q;
    logic        status_clr;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign status_clr = dbg_wr & (idx == STATUS_IDX) & wbs_sel_i[0] & wbs_dat_i[0];
    assign to_hit     = (cnt_q == CNT_LAST);

    // The clear is given priority even though it cannot coincide with TO_ERR today.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_count_q <= '0;
            to_flag_q  <= 1'b0;
        end else if (status_clr) begin
            to_count_q <= '0;
            to_flag_q  <= 1'b0;
        end else if (state_q == TO_ERR) begin
            to_count_q <= sat_inc16(to_count_q);
            to_flag_q  <= 1'b1;
        end
    end

    assign status_word = {to_count_q, 15'd0, to_flag_q};
`else
    assign to_hit      = 1'b0;
    assign status_word = 32'd0;
`endif

    always_comb begin
        dbg_rd = status_word;
        for (int i = 0; i < DBG_REGS - 1; i++) begin
            if (idx == IDX_W'(i)) dbg_rd = scratch_q[32*i +: 32];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            scratch_q <= '0;
        end else if (dbg_wr) begin
            for (int i = 0; i < DBG_REGS - 1; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (idx == IDX_W'(i) && wbs_sel_i[b])
                        scratch_q[32*i + 8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 1: debug read data captured with the request, presented in DBG_ACK.
    always_ff @(posedge wb_clk_i) begin
        if (dbg_hit) rd_dat_p1 <= dbg_rd;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        route   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (is_dbg) begin
                        state_d = DBG_ACK;
                    end else begin
                        route = 1'b1;
                        if (!user_ack_i) state_d = USER;
                    end
                end
            end
            USER: begin
                route = 1'b1;
                if (!wbs_cyc_i)             state_d = IDLE;
                else if (req & user_ack_i)  state_d = IDLE;
                else if (to_hit)            state_d = TO_ERR;
            end
            DBG_ACK, TO_ERR: state_d = IDLE;
            default:         state_d = IDLE;
        endcase
        // Saturation only matters without the watchdog, where USER may wait forever.
        if (state_d == IDLE)
            cnt_d = '0;
        else if (state_d == USER && cnt_q != CNT_LAST)
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        wbs_ack_o = 1'b0;
        wbs_dat_o = '0;
        case (state_q)
            DBG_ACK: begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = rd_dat_p1;
            end
            TO_ERR: begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = 32'hDEAD_BEEF;
            end
            default: begin
                if (route & req & user_ack_i) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = user_dat_i;
                end
            end
        endcase
        // Reset kills the handshake immediately, not at the next edge.
        if (!wb_rst_ni) begin
            wbs_ack_o = 1'b0;
            wbs_dat_o = '0;
        end
    end

    assign user_cyc_o = wb_rst_ni & route & wbs_cyc_i;
    assign user_stb_o = wb_rst_ni & route & wbs_stb_i;

endmodule

// File: tb/tb_wb_debug_split.sv
// Self-checking bench for wb_debug_split: directed vector table, corner sequences and random traffic.
module tb_wb_debug_split;
    localparam int          TO    = 8;
    localparam logic [31:0] SCR_A = 32'h300F_FFF8;
    localparam logic [31:0] STS_A = 32'h300F_FFFC;
`ifdef WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        ucyc, ustb;
    logic        uack = 1'b0;
    logic [31:0] udat = '0;
    logic [31:0] dbg_regs;

    always #5 clk = ~clk;

    wb_debug_split #(.DBG_REGS(2), .WIN_TOP(32'h300F_FFFF), .TIMEOUT_CYC(TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .user_cyc_o(ucyc), .user_stb_o(ustb), .user_ack_i(uack), .user_dat_i(udat),
        .dbg_regs_o(dbg_regs)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: scratch word, timeout count and sticky flag.
    logic [31:0] m_scr  = '0;
    logic [15:0] m_cnt  = '0;
    logic        m_flag = 1'b0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          lat;
        logic [31:0] udat;
        int          exp_cyc;
        logic [31:0] exp_dat;
        bit          chk;
    } tv_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {m_cnt, 15'd0, m_flag};
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        logic [31:0] w;
        w = SCR_A;
        return a[31:3] == w[31:3];
    endfunction

    function automatic tv_t mk(input logic [31:0] a, input logic w, input logic [3:0] s,
                               input logic [31:0] d, input int l, input logic [31:0] ud,
                               input int ec, input logic [31:0] ed, input bit c);
        tv_t v;
        v.adr = a; v.we = w; v.sel = s; v.dat = d; v.lat = l; v.udat = ud;
        v.exp_cyc = ec; v.exp_dat = ed; v.chk = c;
        return v;
    endfunction

    task automatic do_txn(input tv_t v, input string tag);
        bit          is_user, is_to, exp_stb;
        int          got, leak, stb_bad;
        logic [31:0] gdat;
        is_user = !in_window(v.adr);
        is_to   = is_user && TO_EN && (v.lat >= TO);
        got = -1; gdat = '0; leak = 0; stb_bad = 0;
        for (int k = 0; k <= v.exp_cyc + 2; k++) begin
            @(posedge clk); #1;
            cyc = 1'b1; stb = 1'b1; we = v.we; sel = v.sel; adr = v.adr; wdat = v.dat;
            uack = is_user && (k == v.lat);
            udat = uack ? v.udat : $urandom;
            #3;
            exp_stb = is_user && !(is_to && k >= TO);
            if (ustb !== exp_stb || ucyc !== exp_stb) stb_bad++;
            if (ack === 1'b1) begin
                got  = k;
                gdat = dat_o;
                break;
            end
            if (dat_o !== 32'd0) leak++;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        uack = 1'($urandom_range(0, 1));
        #3;
        check({tag, ".ack_cyc"}, 32'(got), 32'(v.exp_cyc));
        if (v.chk) check({tag, ".ack_dat"}, gdat, v.exp_dat);
        check({tag, ".strobes"}, 32'(stb_bad), 32'd0);
        check({tag, ".dat_idle"}, 32'(leak), 32'd0);
        check({tag, ".ack_after"}, {31'd0, ack}, 32'd0);
        uack = 1'b0;
        if (is_to) begin
            m_cnt  = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            m_flag = 1'b1;
        end else if (!is_user && v.we) begin
            if (v.adr[2] == 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (v.sel[b]) m_scr[8*b +: 8] = v.dat[8*b +: 8];
            end else if (TO_EN && v.sel[0] && v.dat[0]) begin
                m_cnt  = '0;
                m_flag = 1'b0;
            end
        end
        check({tag, ".dbg_regs"}, dbg_regs, m_scr);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        tv_t         tbl[$];
        tv_t         v;
        logic [31:0] ts;
        int          abort_ack;
        logic        stb_at4;

        ts = TO_EN ? 32'h0001_0001 : 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.ack", {31'd0, ack}, 32'd0);
        check("rst.dat", dat_o, 32'd0);
        check("rst.strobes", {30'd0, ucyc, ustb}, 32'd0);
        check("rst.dbg_regs", dbg_regs, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        tbl.push_back(mk(STS_A, 1'b0, 4'hF, 0, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(SCR_A, 1'b1, 4'b0011, 32'hA5A5_1234, 0, 0, 1, 0, 0));
        tbl.push_back(mk(SCR_A, 1'b0, 4'hF, 0, 0, 0, 1, 32'h0000_1234, 1));
        tbl.push_back(mk(32'h3000_0010, 1'b0, 4'hF, 0, 3, 32'hCAFE_0001, 3, 32'hCAFE_0001, 1));
        tbl.push_back(mk(STS_A, 1'b0, 4'hF, 0, 0, 0, 1, 32'h0, 1));
`ifdef WB_TIMEOUT_EN
        tbl.push_back(mk(32'h3000_0014, 1'b0, 4'hF, 0, 1000, 0, TO, 32'hDEAD_BEEF, 1));
`else
        tbl.push_back(mk(32'h3000_0014, 1'b0, 4'hF, 0, 12, 32'h1111_2222, 12, 32'h1111_2222, 1));
`endif
        tbl.push_back(mk(STS_A, 1'b0, 4'hF, 0, 0, 0, 1, ts, 1));
        tbl.push_back(mk(32'h3000_0018, 1'b0, 4'hF, 0, TO - 1, 32'h7777_0007, TO - 1, 32'h7777_0007, 1));
        tbl.push_back(mk(STS_A, 1'b0, 4'hF, 0, 0, 0, 1, ts, 1));
        tbl.push_back(mk(STS_A, 1'b1, 4'b0001, 32'h0000_0001, 0, 0, 1, 0, 0));
        tbl.push_back(mk(STS_A, 1'b0, 4'hF, 0, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(SCR_A, 1'b1, 4'b1000, 32'hFFFF_FFFF, 0, 0, 1, 0, 0));
        tbl.push_back(mk(32'h300F_FFFB, 1'b0, 4'hF, 0, 0, 0, 1, 32'hFF00_1234, 1));
        tbl.push_back(mk(32'h300F_FFF4, 1'b0, 4'hF, 0, 0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1));
        tbl.push_back(mk(STS_A, 1'b1, 4'hF, 32'hFFFF_FFFF, 0, 0, 1, 0, 0));
        tbl.push_back(mk(STS_A, 1'b0, 4'hF, 0, 0, 0, 1, 32'h0, 1));
        foreach (tbl[i]) do_txn(tbl[i], $sformatf("vec%0d", i));

        // Master abort in cycle 4, then a full-length access must not time out early.
        abort_ack = 0;
        stb_at4   = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk); #1;
            cyc = (k < 4); stb = (k < 4); we = 1'b0; adr = 32'h3000_0020; uack = 1'b0;
            #3;
            if (ack === 1'b1) abort_ack++;
            if (k == 4) stb_at4 = ustb | ucyc;
        end
        check("abort.no_ack", 32'(abort_ack), 32'd0);
        check("abort.strobes", {31'd0, stb_at4}, 32'd0);
        do_txn(mk(32'h3000_0024, 1'b0, 4'hF, 0, TO - 1, 32'h5A5A_0001, TO - 1, 32'h5A5A_0001, 1), "post_abort");

        // Reset in the middle of a pending user access with a late ack on the bus.
        do_txn(mk(SCR_A, 1'b1, 4'hF, 32'h1357_9BDF, 0, 0, 1, 0, 0), "pre_rst_wr");
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0040; uack = 1'b0;
        @(posedge clk); #1;
        check("midrst.pre_stb", {31'd0, ustb}, 32'd1);
        uack = 1'b1; udat = 32'h4444_4444;
        rst_n = 1'b0;
        #1;
        check("midrst.ack", {31'd0, ack}, 32'd0);
        check("midrst.strobes", {30'd0, ucyc, ustb}, 32'd0);
        check("midrst.dbg_regs", dbg_regs, 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; uack = 1'b0;
        rst_n = 1'b1;
        m_scr = '0; m_cnt = '0; m_flag = 1'b0;
        do_txn(mk(SCR_A, 1'b0, 4'hF, 0, 0, 0, 1, 32'h0, 1), "post_rst_scr");
        do_txn(mk(STS_A, 1'b0, 4'hF, 0, 0, 0, 1, 32'h0, 1), "post_rst_sts");

        // Random traffic against the reference state.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic ib;
                ib = 1'($urandom_range(0, 1));
                v = mk({SCR_A[31:3], ib, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), $urandom, 0, 0, 1, 0, 0);
                v.exp_dat = ib ? m_status() : m_scr;
                v.chk     = !v.we;
            end else begin
                v = mk(32'h3000_0000 + ($urandom_range(0, 4095) << 2), 1'($urandom_range(0, 1)),
                       4'hF, $urandom, 0, $urandom, 0, 0, 1);
                v.lat = TO_EN ? $urandom_range(0, TO + 3) : $urandom_range(0, 12);
                if (TO_EN && v.lat >= TO) begin
                    v.exp_cyc = TO;
                    v.exp_dat = 32'hDEAD_BEEF;
                end else begin
                    v.exp_cyc = v.lat;
                    v.exp_dat = v.udat;
                end
            end
            do_txn(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
